// File: rtl/ahb_lite_arbiter2_pkg.sv
// Shared AHB-Lite codes, arbiter state encoding and the captured address-phase record
// used by the two-master arbiter.
package ahb_lite_arbiter2_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  burst;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic        write;
    } ahb_addr_t;

    // Undefined-length INCR is treated like SINGLE: one beat, never locked.
    function automatic logic [4:0] burst_beats(input logic [2:0] burst);
        logic [4:0] beats;
        case (burst)
            HBURST_SINGLE, HBURST_INCR:   beats = 5'd1;
            HBURST_WRAP4, HBURST_INCR4:   beats = 5'd4;
            HBURST_WRAP8, HBURST_INCR8:   beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
            default:                      beats = 5'd1;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_lite_arbiter2_capture.sv
// Per-master address-phase holding register, pending flag and HREADY qualification.
// o_req/o_req_* present the request as it will look after this edge (pending or capturing now).
module ahb_lite_arbiter2_capture
    import ahb_lite_arbiter2_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_haddr,
    input  logic [2:0]  i_hburst,
    input  logic [2:0]  i_hsize,
    input  logic [1:0]  i_htrans,
    input  logic        i_hsel,
    input  logic        i_hwrite,
    input  logic        i_in_data,
    input  logic        i_s_hreadyout,
    input  logic        i_accept,
    output logic        o_hready,
    output logic        o_req,
    output logic        o_idle,
    output logic [2:0]  o_req_burst,
    output logic [1:0]  o_req_trans,
    output ahb_addr_t   o_hold
);

    logic      r_pend;
    ahb_addr_t r_hold;
    ahb_addr_t w_live;
    logic      w_cap;

    assign w_live      = '{addr: i_haddr, burst: i_hburst, size: i_hsize,
                           trans: i_htrans, write: i_hwrite};
    assign o_hready    = i_in_data ? i_s_hreadyout : ~r_pend;
    assign w_cap       = o_hready & i_hsel & i_htrans[1];
    assign o_req       = w_cap | r_pend;
    assign o_idle      = o_hready & (i_htrans == HTRANS_IDLE);
    assign o_req_burst = w_cap ? i_hburst : r_hold.burst;
    assign o_req_trans = w_cap ? i_htrans : r_hold.trans;
    assign o_hold      = r_hold;

    // Latch the master's address phase; pend holds until the slave accepts it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend <= 1'b0;
            r_hold <= '0;
        end else if (w_cap) begin
            r_pend <= 1'b1;
            r_hold <= w_live;
        end else if (i_accept) begin
            r_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/ahb_lite_arbiter2.sv
// Two-master to one-slave AHB-Lite arbiter: captured address phases are replayed to the
// slave under round-robin or fixed priority, and fixed-length bursts are locked to one owner.
module ahb_lite_arbiter2
    import ahb_lite_arbiter2_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int BUSY_LIMIT = 15
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] M0_HADDR,
    input  logic [2:0]  M0_HBURST,
    input  logic [2:0]  M0_HSIZE,
    input  logic [1:0]  M0_HTRANS,
    input  logic        M0_HSEL,
    input  logic        M0_HWRITE,
    input  logic [31:0] M0_HWDATA,
    output logic [31:0] M0_HRDATA,
    output logic        M0_HREADY,
    output logic        M0_HRESP,
    input  logic [31:0] M1_HADDR,
    input  logic [2:0]  M1_HBURST,
    input  logic [2:0]  M1_HSIZE,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M1_HSEL,
    input  logic        M1_HWRITE,
    input  logic [31:0] M1_HWDATA,
    output logic [31:0] M1_HRDATA,
    output logic        M1_HREADY,
    output logic        M1_HRESP,
    output logic [31:0] S_HADDR,
    output logic [2:0]  S_HBURST,
    output logic [2:0]  S_HSIZE,
    output logic [1:0]  S_HTRANS,
    output logic        S_HSEL,
    output logic        S_HWRITE,
    output logic [31:0] S_HWDATA,
    input  logic [31:0] S_HRDATA,
    input  logic        S_HREADYOUT,
    input  logic        S_HRESP,
    output logic        S_HREADY,
    output logic [1:0]  GRANT
);

    localparam logic [4:0] LP_BUSY_LIMIT = 5'(BUSY_LIMIT);

    arb_state_t r_state;
    logic       r_owner;
    logic       r_last_grant;
    logic       r_first;
    logic [4:0] r_beats;
    logic [3:0] r_busy;

    logic       w_req0, w_req1, w_idle0, w_idle1;
    logic [2:0] w_burst0, w_burst1;
    logic [1:0] w_trans0, w_trans1;
    ahb_addr_t  w_hold0, w_hold1, w_hold_own;
    logic       w_in_data0, w_in_data1, w_accept0, w_accept1;
    logic       w_win, w_req_own, w_idle_own, w_busy_hit, w_drive;
    logic [1:0] w_trans_own;

    assign w_in_data0 = (r_state == ST_DATA) & ~r_owner;
    assign w_in_data1 = (r_state == ST_DATA) &  r_owner;
    assign w_accept0  = (r_state == ST_ADDR) & S_HREADYOUT & ~r_owner;
    assign w_accept1  = (r_state == ST_ADDR) & S_HREADYOUT &  r_owner;

    ahb_lite_arbiter2_capture u_cap0 (
        .i_clk(HCLK), .i_rst(HRESET),
        .i_haddr(M0_HADDR), .i_hburst(M0_HBURST), .i_hsize(M0_HSIZE),
        .i_htrans(M0_HTRANS), .i_hsel(M0_HSEL), .i_hwrite(M0_HWRITE),
        .i_in_data(w_in_data0), .i_s_hreadyout(S_HREADYOUT), .i_accept(w_accept0),
        .o_hready(M0_HREADY), .o_req(w_req0), .o_idle(w_idle0),
        .o_req_burst(w_burst0), .o_req_trans(w_trans0), .o_hold(w_hold0)
    );

    ahb_lite_arbiter2_capture u_cap1 (
        .i_clk(HCLK), .i_rst(HRESET),
        .i_haddr(M1_HADDR), .i_hburst(M1_HBURST), .i_hsize(M1_HSIZE),
        .i_htrans(M1_HTRANS), .i_hsel(M1_HSEL), .i_hwrite(M1_HWRITE),
        .i_in_data(w_in_data1), .i_s_hreadyout(S_HREADYOUT), .i_accept(w_accept1),
        .o_hready(M1_HREADY), .o_req(w_req1), .o_idle(w_idle1),
        .o_req_burst(w_burst1), .o_req_trans(w_trans1), .o_hold(w_hold1)
    );

    assign w_req_own   = r_owner ? w_req1   : w_req0;
    assign w_idle_own  = r_owner ? w_idle1  : w_idle0;
    assign w_trans_own = r_owner ? w_trans1 : w_trans0;
    assign w_hold_own  = r_owner ? w_hold1  : w_hold0;
    assign w_busy_hit  = ({1'b0, r_busy} + 5'd1) >= LP_BUSY_LIMIT;

    // Winner for the next arbitration round.
    always_comb begin
        w_win = 1'b0;
        if (FIXED_PRIO != 0) begin
            w_win = ~w_req0;
        end else if (w_req0 && w_req1) begin
            w_win = ~r_last_grant;
        end else begin
            w_win = w_req1;
        end
    end

    // Arbiter FSM; r_beats counts beats still to be issued, so zero in DATA marks the last beat.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_first      <= 1'b0;
            r_beats      <= 5'd0;
            r_busy       <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 4'd0;
                    if (w_req0 || w_req1) begin
                        r_owner      <= w_win;
                        r_last_grant <= w_win;
                        r_first      <= 1'b1;
                        r_beats      <= burst_beats(w_win ? w_burst1 : w_burst0);
                        r_state      <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (S_HREADYOUT) begin
                        r_beats <= r_beats - 5'd1;
                        r_first <= 1'b0;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    r_busy <= 4'd0;
                    if (S_HREADYOUT) begin
                        if (S_HRESP || r_beats == 5'd0) begin
                            r_beats <= 5'd0;
                            r_state <= ST_IDLE;
                        end else if (w_req_own && w_trans_own == HTRANS_SEQ) begin
                            r_state <= ST_ADDR;
                        end else if (w_req_own) begin
                            r_beats <= 5'd0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_req_own && w_trans_own == HTRANS_SEQ) begin
                        r_busy  <= 4'd0;
                        r_state <= ST_ADDR;
                    end else if (w_req_own || w_idle_own || w_busy_hit) begin
                        r_busy  <= 4'd0;
                        r_beats <= 5'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_busy  <= r_busy + 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Slave transfer type; only the first beat after arbitration is forced to NONSEQ.
    always_comb begin
        S_HTRANS = HTRANS_IDLE;
        case (r_state)
            ST_IDLE: S_HTRANS = HTRANS_IDLE;
            ST_ADDR: S_HTRANS = r_first ? HTRANS_NONSEQ : w_hold_own.trans;
            ST_DATA: S_HTRANS = (r_beats != 5'd0) ? HTRANS_BUSY : HTRANS_IDLE;
            ST_HOLD: S_HTRANS = HTRANS_BUSY;
            default: S_HTRANS = HTRANS_IDLE;
        endcase
    end

    assign w_drive   = (r_state != ST_IDLE);
    assign S_HSEL    = w_drive;
    assign S_HADDR   = w_drive ? w_hold_own.addr  : 32'd0;
    assign S_HBURST  = w_drive ? w_hold_own.burst : 3'd0;
    assign S_HSIZE   = w_drive ? w_hold_own.size  : 3'd0;
    assign S_HWRITE  = w_drive ? w_hold_own.write : 1'b0;
    assign S_HWDATA  = w_in_data0 ? M0_HWDATA : (w_in_data1 ? M1_HWDATA : 32'd0);
    assign S_HREADY  = S_HREADYOUT;
    assign M0_HRDATA = w_in_data0 ? S_HRDATA : 32'd0;
    assign M1_HRDATA = w_in_data1 ? S_HRDATA : 32'd0;
    assign M0_HRESP  = w_in_data0 ? S_HRESP : 1'b0;
    assign M1_HRESP  = w_in_data1 ? S_HRESP : 1'b0;
    assign GRANT     = w_drive ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_ahb_lite_arbiter2.sv
// Directed bench for ahb_lite_arbiter2: every step drives both masters and the slave
// response, then checks the arbiter's outputs against hand-derived values.
module tb_ahb_lite_arbiter2;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
    logic [2:0]  M0_HBURST, M1_HBURST, M0_HSIZE, M1_HSIZE;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic        M0_HSEL, M1_HSEL, M0_HWRITE, M1_HWRITE;
    logic [31:0] M0_HRDATA, M1_HRDATA;
    logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
    logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
    logic [2:0]  S_HBURST, S_HSIZE;
    logic [1:0]  S_HTRANS, GRANT;
    logic        S_HSEL, S_HWRITE, S_HREADYOUT, S_HRESP, S_HREADY;

    int n_cmp = 0;
    int n_err = 0;

    ahb_lite_arbiter2 #(.FIXED_PRIO(0), .BUSY_LIMIT(15)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_HADDR(M0_HADDR), .M0_HBURST(M0_HBURST), .M0_HSIZE(M0_HSIZE),
        .M0_HTRANS(M0_HTRANS), .M0_HSEL(M0_HSEL), .M0_HWRITE(M0_HWRITE),
        .M0_HWDATA(M0_HWDATA), .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY),
        .M0_HRESP(M0_HRESP),
        .M1_HADDR(M1_HADDR), .M1_HBURST(M1_HBURST), .M1_HSIZE(M1_HSIZE),
        .M1_HTRANS(M1_HTRANS), .M1_HSEL(M1_HSEL), .M1_HWRITE(M1_HWRITE),
        .M1_HWDATA(M1_HWDATA), .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY),
        .M1_HRESP(M1_HRESP),
        .S_HADDR(S_HADDR), .S_HBURST(S_HBURST), .S_HSIZE(S_HSIZE),
        .S_HTRANS(S_HTRANS), .S_HSEL(S_HSEL), .S_HWRITE(S_HWRITE),
        .S_HWDATA(S_HWDATA), .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT),
        .S_HRESP(S_HRESP), .S_HREADY(S_HREADY), .GRANT(GRANT)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m0(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] b,
                      input logic w);
        M0_HSEL = 1'b1; M0_HTRANS = tr; M0_HADDR = a; M0_HBURST = b;
        M0_HWRITE = w; M0_HSIZE = 3'b010;
    endtask

    task automatic m1(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] b,
                      input logic w);
        M1_HSEL = 1'b1; M1_HTRANS = tr; M1_HADDR = a; M1_HBURST = b;
        M1_HWRITE = w; M1_HSIZE = 3'b010;
    endtask

    task automatic step();
        @(negedge HCLK);
    endtask

    initial begin
        HRESET = 1'b1;
        m0(2'b00, 32'h0, 3'b000, 1'b0); m1(2'b00, 32'h0, 3'b000, 1'b0);
        M0_HSEL = 1'b0; M1_HSEL = 1'b0;
        M0_HWDATA = 32'h0; M1_HWDATA = 32'h0;
        S_HRDATA = 32'h0; S_HREADYOUT = 1'b1; S_HRESP = 1'b0;

        // Reset values
        step(); step(); #1;
        chk("rst_grant", {30'd0, GRANT}, 32'd0);
        chk("rst_m0_hready", {31'd0, M0_HREADY}, 32'd1);
        chk("rst_m1_hready", {31'd0, M1_HREADY}, 32'd1);
        chk("rst_s_hsel", {31'd0, S_HSEL}, 32'd0);
        chk("rst_s_htrans", {30'd0, S_HTRANS}, 32'd0);
        chk("rst_s_haddr", S_HADDR, 32'd0);
        chk("rst_m0_hrdata", M0_HRDATA, 32'd0);
        HRESET = 1'b0;

        // Single read from M0 with three slave wait states
        step(); m0(2'b10, 32'h100, 3'b000, 1'b0); #1;
        chk("t1_cap_hready", {31'd0, M0_HREADY}, 32'd1);
        step(); m0(2'b00, 32'h100, 3'b000, 1'b0); #1;
        chk("t1_s_haddr", S_HADDR, 32'h100);
        chk("t1_s_htrans", {30'd0, S_HTRANS}, 32'd2);
        chk("t1_grant", {30'd0, GRANT}, 32'd1);
        chk("t1_addr_hready", {31'd0, M0_HREADY}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(); S_HREADYOUT = 1'b0; #1;
            chk("t1_wait_hready", {31'd0, M0_HREADY}, 32'd0);
        end
        step(); S_HREADYOUT = 1'b1; S_HRDATA = 32'hDEADBEEF; #1;
        chk("t1_done_hready", {31'd0, M0_HREADY}, 32'd1);
        chk("t1_m0_hrdata", M0_HRDATA, 32'hDEADBEEF);
        chk("t1_m1_hrdata", M1_HRDATA, 32'd0);
        step(); S_HRDATA = 32'h0; #1;
        chk("t1_idle_grant", {30'd0, GRANT}, 32'd0);
        chk("t1_idle_hrdata", M0_HRDATA, 32'd0);

        // Re-reset so round-robin starts from M0
        step(); HRESET = 1'b1;
        step(); HRESET = 1'b0;

        // Simultaneous single writes, round-robin order M0, M1, M0, M1
        step(); m0(2'b10, 32'h200, 3'b000, 1'b1); m1(2'b10, 32'h300, 3'b000, 1'b1);
        step(); m0(2'b00, 32'h0, 3'b000, 1'b0); m1(2'b00, 32'h0, 3'b000, 1'b0);
        M0_HWDATA = 32'hA0A00000; M1_HWDATA = 32'hB1B10000; #1;
        chk("rr_a_grant", {30'd0, GRANT}, 32'd1);
        chk("rr_a_haddr", S_HADDR, 32'h200);
        chk("rr_a_hwrite", {31'd0, S_HWRITE}, 32'd1);
        chk("rr_a_m1_hready", {31'd0, M1_HREADY}, 32'd0);
        step(); m0(2'b10, 32'h204, 3'b000, 1'b1); #1;
        chk("rr_a_hwdata", S_HWDATA, 32'hA0A00000);
        chk("rr_a_m0_done", {31'd0, M0_HREADY}, 32'd1);
        chk("rr_a_m1_wait", {31'd0, M1_HREADY}, 32'd0);
        step(); m0(2'b00, 32'h0, 3'b000, 1'b0); M0_HWDATA = 32'hA0A00001; #1;
        chk("rr_gap_grant", {30'd0, GRANT}, 32'd0);
        step(); #1;
        chk("rr_b_grant", {30'd0, GRANT}, 32'd2);
        chk("rr_b_haddr", S_HADDR, 32'h300);
        chk("rr_b_m0_wait", {31'd0, M0_HREADY}, 32'd0);
        step(); m1(2'b10, 32'h304, 3'b000, 1'b1); #1;
        chk("rr_b_hwdata", S_HWDATA, 32'hB1B10000);
        chk("rr_b_m1_done", {31'd0, M1_HREADY}, 32'd1);
        step(); m1(2'b00, 32'h0, 3'b000, 1'b0); M1_HWDATA = 32'hB1B10001; #1;
        step(); #1;
        chk("rr_c_grant", {30'd0, GRANT}, 32'd1);
        chk("rr_c_haddr", S_HADDR, 32'h204);
        step(); #1;
        chk("rr_c_hwdata", S_HWDATA, 32'hA0A00001);
        chk("rr_c_m1_wait", {31'd0, M1_HREADY}, 32'd0);
        step(); step(); #1;
        chk("rr_d_grant", {30'd0, GRANT}, 32'd2);
        chk("rr_d_haddr", S_HADDR, 32'h304);
        step(); #1;
        chk("rr_d_hwdata", S_HWDATA, 32'hB1B10001);
        step(); #1;
        chk("rr_end_grant", {30'd0, GRANT}, 32'd0);

        // WRAP4 write from M1 stays locked while M0 requests after beat 1
        step(); m1(2'b10, 32'h20, 3'b010, 1'b1);
        step(); m1(2'b11, 32'h24, 3'b010, 1'b1); M1_HWDATA = 32'hD0; #1;
        chk("wr_b0_haddr", S_HADDR, 32'h20);
        chk("wr_b0_htrans", {30'd0, S_HTRANS}, 32'd2);
        chk("wr_b0_grant", {30'd0, GRANT}, 32'd2);
        step(); m0(2'b10, 32'h400, 3'b000, 1'b0); #1;
        chk("wr_d0_htrans", {30'd0, S_HTRANS}, 32'd1);
        chk("wr_d0_hwdata", S_HWDATA, 32'hD0);
        step(); m0(2'b00, 32'h0, 3'b000, 1'b0);
        m1(2'b11, 32'h28, 3'b010, 1'b1); M1_HWDATA = 32'hD1; #1;
        chk("wr_b1_haddr", S_HADDR, 32'h24);
        chk("wr_b1_htrans", {30'd0, S_HTRANS}, 32'd3);
        chk("wr_b1_m0_wait", {31'd0, M0_HREADY}, 32'd0);
        step(); #1;
        chk("wr_d1_htrans", {30'd0, S_HTRANS}, 32'd1);
        chk("wr_d1_hwdata", S_HWDATA, 32'hD1);
        step(); m1(2'b11, 32'h2C, 3'b010, 1'b1); M1_HWDATA = 32'hD2; #1;
        chk("wr_b2_haddr", S_HADDR, 32'h28);
        step(); #1;
        chk("wr_d2_htrans", {30'd0, S_HTRANS}, 32'd1);
        step(); m1(2'b00, 32'h0, 3'b000, 1'b0); M1_HWDATA = 32'hD3; #1;
        chk("wr_b3_haddr", S_HADDR, 32'h2C);
        chk("wr_b3_grant", {30'd0, GRANT}, 32'd2);
        step(); #1;
        chk("wr_d3_htrans", {30'd0, S_HTRANS}, 32'd0);
        chk("wr_d3_hwdata", S_HWDATA, 32'hD3);
        chk("wr_d3_m0_wait", {31'd0, M0_HREADY}, 32'd0);
        step(); #1;
        chk("wr_gap_grant", {30'd0, GRANT}, 32'd0);
        step(); #1;
        chk("wr_m0_haddr", S_HADDR, 32'h400);
        chk("wr_m0_grant", {30'd0, GRANT}, 32'd1);
        step(); S_HRDATA = 32'h12345678; #1;
        chk("wr_m0_hrdata", M0_HRDATA, 32'h12345678);
        step(); S_HRDATA = 32'h0;

        // INCR4 from M0 abandoned after beat 2; pending M1 is granted next
        step(); m0(2'b10, 32'h500, 3'b011, 1'b0);
        step(); m0(2'b11, 32'h504, 3'b011, 1'b0); m1(2'b10, 32'h600, 3'b000, 1'b1); #1;
        chk("ab_b0_haddr", S_HADDR, 32'h500);
        step(); m1(2'b00, 32'h0, 3'b000, 1'b0); M1_HWDATA = 32'hC0FFEE00; #1;
        chk("ab_d0_htrans", {30'd0, S_HTRANS}, 32'd1);
        chk("ab_d0_m1_wait", {31'd0, M1_HREADY}, 32'd0);
        step(); m0(2'b00, 32'h0, 3'b000, 1'b0); #1;
        chk("ab_b1_haddr", S_HADDR, 32'h504);
        chk("ab_b1_htrans", {30'd0, S_HTRANS}, 32'd3);
        step(); #1;
        chk("ab_d1_htrans", {30'd0, S_HTRANS}, 32'd1);
        step(); #1;
        chk("ab_hold_htrans", {30'd0, S_HTRANS}, 32'd1);
        chk("ab_hold_hsel", {31'd0, S_HSEL}, 32'd1);
        chk("ab_hold_grant", {30'd0, GRANT}, 32'd1);
        step(); #1;
        chk("ab_rel_grant", {30'd0, GRANT}, 32'd0);
        step(); #1;
        chk("ab_m1_grant", {30'd0, GRANT}, 32'd2);
        chk("ab_m1_haddr", S_HADDR, 32'h600);
        chk("ab_m1_htrans", {30'd0, S_HTRANS}, 32'd2);
        step(); #1;
        chk("ab_m1_hwdata", S_HWDATA, 32'hC0FFEE00);
        step();

        // Two-cycle ERROR on beat 1 of an M0 INCR4
        step(); m0(2'b10, 32'h700, 3'b011, 1'b0);
        step(); m0(2'b11, 32'h704, 3'b011, 1'b0);
        step(); S_HREADYOUT = 1'b0; S_HRESP = 1'b1; #1;
        chk("er_c1_hresp", {31'd0, M0_HRESP}, 32'd1);
        chk("er_c1_hready", {31'd0, M0_HREADY}, 32'd0);
        step(); S_HREADYOUT = 1'b1; m0(2'b00, 32'h0, 3'b000, 1'b0); #1;
        chk("er_c2_hresp", {31'd0, M0_HRESP}, 32'd1);
        chk("er_c2_hready", {31'd0, M0_HREADY}, 32'd1);
        step(); S_HRESP = 1'b0; #1;
        chk("er_idle_grant", {30'd0, GRANT}, 32'd0);
        chk("er_idle_hresp", {31'd0, M0_HRESP}, 32'd0);
        step(); #1;
        chk("er_nolock_grant", {30'd0, GRANT}, 32'd0);
        chk("er_nolock_htrans", {30'd0, S_HTRANS}, 32'd0);

        // Asynchronous reset while M1 is in DATA
        step(); m1(2'b10, 32'h800, 3'b000, 1'b0);
        step(); m1(2'b00, 32'h0, 3'b000, 1'b0); #1;
        chk("ar_addr_grant", {30'd0, GRANT}, 32'd2);
        step(); S_HREADYOUT = 1'b0; S_HRDATA = 32'h55AA55AA; #1;
        chk("ar_data_hrdata", M1_HRDATA, 32'h55AA55AA);
        #1 HRESET = 1'b1; #1;
        chk("ar_grant", {30'd0, GRANT}, 32'd0);
        chk("ar_hsel", {31'd0, S_HSEL}, 32'd0);
        chk("ar_htrans", {30'd0, S_HTRANS}, 32'd0);
        chk("ar_haddr", S_HADDR, 32'd0);
        chk("ar_m1_hready", {31'd0, M1_HREADY}, 32'd1);
        chk("ar_m1_hrdata", M1_HRDATA, 32'd0);
        step(); HRESET = 1'b0; S_HREADYOUT = 1'b1; S_HRDATA = 32'h0;
        m0(2'b10, 32'h900, 3'b000, 1'b1); #1;
        chk("ar_cap_hready", {31'd0, M0_HREADY}, 32'd1);
        step(); m0(2'b00, 32'h0, 3'b000, 1'b0); M0_HWDATA = 32'h900D900D; #1;
        chk("ar_post_haddr", S_HADDR, 32'h900);
        chk("ar_post_grant", {30'd0, GRANT}, 32'd1);
        step(); #1;
        chk("ar_post_hwdata", S_HWDATA, 32'h900D900D);
        chk("ar_post_hready", {31'd0, M0_HREADY}, 32'd1);
        step(); #1;
        chk("ar_post_idle", {30'd0, GRANT}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
